// File: rtl/rab_inv_pkg.sv
// Shared types and helpers for the RAB range-invalidation engine.
package rab_inv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        L1,
        L2_WALK,
        DRAIN,
        DONE
    } inv_state_e;

    // Widest address the overlap helper handles; callers zero-extend into it.
    localparam int MAX_AW = 64;
    typedef logic [MAX_AW-1:0] addr_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic range_overlap(
        input addr_t a_start,
        input addr_t a_end,
        input addr_t b_start,
        input addr_t b_end
    );
        return (a_start <= b_end) && (a_end >= b_start);
    endfunction

endpackage

// File: rtl/rab_inv_l1_match.sv
// Combinational overlap vector of every L1 slice against one query range.
module rab_inv_l1_match
    import rab_inv_pkg::*;
#(
    parameter int AW       = 32,
    parameter int N_SLICES = 16
) (
    input  logic [N_SLICES*AW-1:0] slice_start,
    input  logic [N_SLICES*AW-1:0] slice_end,
    input  logic [N_SLICES-1:0]    slice_en,
    input  logic [AW-1:0]          q_start,
    input  logic [AW-1:0]          q_end,
    input  logic                   q_all,
    input  logic                   q_empty,
    output logic [N_SLICES-1:0]    hit
);

    always_comb begin
        hit = '0;
        for (int i = 0; i < N_SLICES; i++) begin
            hit[i] = slice_en[i] &&
                     (q_all || (!q_empty &&
                      range_overlap(addr_t'(slice_start[i*AW +: AW]),
                                    addr_t'(slice_end[i*AW +: AW]),
                                    addr_t'(q_start),
                                    addr_t'(q_end))));
        end
    end

endmodule

// File: rtl/rab_inv_engine.sv
// Range-invalidation engine: clears overlapping L1 slices in one cycle, then
// walks every L2 entry through a pipelined read/compare/clear port.
module rab_inv_engine
    import rab_inv_pkg::*;
#(
    parameter  int AW               = 32,
    parameter  int N_SLICES         = 16,
    parameter  int L2_N_SETS        = 32,
    parameter  int L2_N_SET_ENTRIES = 32,
    parameter  int PAGE_SHIFT       = 12,
    parameter  int L2_EN            = 1,
    localparam int N_L2             = L2_N_SETS * L2_N_SET_ENTRIES,
    localparam int IDXW             = idx_width(N_L2)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [AW-1:0]            req_start_i,
    input  logic [AW-1:0]            req_end_i,
    input  logic                     req_all_i,
    input  logic [N_SLICES*AW-1:0]   l1_start_i,
    input  logic [N_SLICES*AW-1:0]   l1_end_i,
    input  logic [N_SLICES-1:0]      l1_en_i,
    output logic [N_SLICES-1:0]      l1_clr_o,
    output logic                     l2_rd_en_o,
    output logic [IDXW-1:0]          l2_rd_addr_o,
    input  logic [AW-PAGE_SHIFT-1:0] l2_rd_vpn_i,
    input  logic                     l2_rd_valid_i,
    output logic                     l2_clr_o,
    output logic [IDXW-1:0]          l2_clr_addr_o,
    output logic                     cfg_lock_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_L2 - 1);

    inv_state_e          state;
    logic [IDXW-1:0]     idx;
    logic [IDXW-1:0]     cmp_idx;
    logic                cmp_valid;
    logic [AW-1:0]       lat_start;
    logic [AW-1:0]       lat_end;
    logic                lat_all;
    logic [N_SLICES-1:0] l1_hit;
    logic [N_SLICES-1:0] l1_clr;
    logic                accept;
    logic                req_empty;
    logic                lat_empty;
    logic [AW-1:0]       page_start;
    logic [AW-1:0]       page_end;
    logic                l2_hit;

    assign accept    = req_valid_i && (state == IDLE);
    assign req_empty = req_end_i < req_start_i;
    assign lat_empty = lat_end < lat_start;

    // Slice config is locked while busy, so matching at accept time is final.
    rab_inv_l1_match #(
        .AW       (AW),
        .N_SLICES (N_SLICES)
    ) u_l1_match (
        .slice_start (l1_start_i),
        .slice_end   (l1_end_i),
        .slice_en    (l1_en_i),
        .q_start     (req_start_i),
        .q_end       (req_end_i),
        .q_all       (req_all_i),
        .q_empty     (req_empty),
        .hit         (l1_hit)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            idx       <= '0;
            cmp_idx   <= '0;
            cmp_valid <= 1'b0;
            lat_start <= '0;
            lat_end   <= '0;
            lat_all   <= 1'b0;
            l1_clr    <= '0;
        end else begin
            l1_clr    <= '0;
            cmp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_start <= req_start_i;
                        lat_end   <= req_end_i;
                        lat_all   <= req_all_i;
                        l1_clr    <= l1_hit;
                        idx       <= '0;
                        state     <= L1;
                    end
                end
                L1: begin
                    state <= (L2_EN != 0) ? L2_WALK : DONE;
                end
                // Each read's response is compared one cycle later in cmp_idx.
                L2_WALK: begin
                    cmp_valid <= 1'b1;
                    cmp_idx   <= idx;
                    if (idx == LAST_IDX) begin
                        state <= DRAIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign page_start = {l2_rd_vpn_i, {PAGE_SHIFT{1'b0}}};
    assign page_end   = {l2_rd_vpn_i, {PAGE_SHIFT{1'b1}}};
    assign l2_hit     = l2_rd_valid_i &&
                        (lat_all || (!lat_empty &&
                         range_overlap(addr_t'(page_start), addr_t'(page_end),
                                       addr_t'(lat_start), addr_t'(lat_end))));

    assign req_ready_o   = (state == IDLE);
    assign busy_o        = (state != IDLE);
    assign cfg_lock_o    = (state != IDLE);
    assign done_o        = (state == DONE);
    assign l1_clr_o      = l1_clr;
    assign l2_rd_en_o    = (state == L2_WALK);
    assign l2_rd_addr_o  = (state == L2_WALK) ? idx : '0;
    assign l2_clr_o      = cmp_valid && l2_hit;
    assign l2_clr_addr_o = cmp_valid ? cmp_idx : '0;

endmodule

// File: tb/tb_rab_inv_engine.sv
// Self-checking bench for rab_inv_engine: vector table, corner sequences and
// randomized requests against a behavioural range-overlap model.
module tb_rab_inv_engine;

    localparam int AW       = 32;
    localparam int N_SLICES = 16;
    localparam int N_L2     = 1024;
    localparam int IDXW     = 10;
    localparam int VPNW     = 20;
    localparam int LATENCY  = N_L2 + 3;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] re;
        logic        all;
        logic [15:0] en;
        int          mode;
        logic [15:0] exp_l1;
        int          exp_n;
        int          exp_a;
        int          exp_b;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   req_valid;
    logic                   req_ready_o;
    logic [AW-1:0]          req_start;
    logic [AW-1:0]          req_end;
    logic                   req_all;
    logic [N_SLICES*AW-1:0] l1_start;
    logic [N_SLICES*AW-1:0] l1_end;
    logic [N_SLICES-1:0]    l1_en;
    logic [N_SLICES-1:0]    l1_clr_o;
    logic                   l2_rd_en_o;
    logic [IDXW-1:0]        l2_rd_addr_o;
    logic [VPNW-1:0]        rd_vpn;
    logic                   rd_valid;
    logic                   l2_clr_o;
    logic [IDXW-1:0]        l2_clr_addr_o;
    logic                   cfg_lock_o;
    logic                   busy_o;
    logic                   done_o;

    logic [VPNW-1:0] vpn_mem [N_L2];
    logic            valid_mem [N_L2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int l1_pulses = 0;
    logic [15:0] l1_last = '0;
    int l1_cyc = 0;
    int l2_q[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int rd_cnt = 0;
    int rd_bad = 0;
    logic prev_rd_en = 1'b0;
    int prev_rd_addr = 0;
    int lock_bad = 0;

    int snap_l1p, snap_l2, snap_done, snap_rd, acc_cyc;
    int exp_q[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    rab_inv_engine dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready_o),
        .req_start_i   (req_start),
        .req_end_i     (req_end),
        .req_all_i     (req_all),
        .l1_start_i    (l1_start),
        .l1_end_i      (l1_end),
        .l1_en_i       (l1_en),
        .l1_clr_o      (l1_clr_o),
        .l2_rd_en_o    (l2_rd_en_o),
        .l2_rd_addr_o  (l2_rd_addr_o),
        .l2_rd_vpn_i   (rd_vpn),
        .l2_rd_valid_i (rd_valid),
        .l2_clr_o      (l2_clr_o),
        .l2_clr_addr_o (l2_clr_addr_o),
        .cfg_lock_o    (cfg_lock_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // L2 tag RAM: one-cycle read latency; garbage on the bus when not reading.
    always @(posedge clk) begin
        if (l2_rd_en_o) begin
            rd_vpn   <= vpn_mem[l2_rd_addr_o];
            rd_valid <= valid_mem[l2_rd_addr_o];
        end else begin
            rd_vpn   <= VPNW'($urandom);
            rd_valid <= 1'b1;
        end
    end

    // Observe DUT outputs away from the active edge and log every event.
    always @(negedge clk) begin
        if (l1_clr_o != '0) begin
            l1_pulses <= l1_pulses + 1;
            l1_last   <= l1_clr_o;
            l1_cyc    <= cyc;
        end
        if (l2_clr_o) l2_q.push_back(int'(l2_clr_addr_o));
        if (done_o) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (l2_rd_en_o) begin
            if (int'(l2_rd_addr_o) != (prev_rd_en ? prev_rd_addr + 1 : 0)) rd_bad <= rd_bad + 1;
            rd_cnt <= rd_cnt + 1;
        end
        prev_rd_en   <= l2_rd_en_o;
        prev_rd_addr <= int'(l2_rd_addr_o);
        if (rst_n && ((req_ready_o == busy_o) || (cfg_lock_o != busy_o))) lock_bad <= lock_bad + 1;
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic set_layout();
        for (int i = 0; i < N_SLICES; i++) begin
            l1_start[i*AW +: AW] = 32'h4000 + 32'(i) * 32'h1000;
            l1_end[i*AW +: AW]   = 32'h4000 + 32'(i) * 32'h1000 + 32'hFFF;
        end
    endtask

    task automatic set_rand_layout();
        logic [31:0] s;
        for (int i = 0; i < N_SLICES; i++) begin
            s = 32'($urandom_range(0, 32'h20000));
            l1_start[i*AW +: AW] = s;
            l1_end[i*AW +: AW]   = s + 32'($urandom_range(0, 32'h3000));
        end
    endtask

    task automatic load_mem(input int mode);
        for (int k = 0; k < N_L2; k++) begin
            case (mode)
                0: begin vpn_mem[k] = VPNW'(k); valid_mem[k] = 1'b1; end
                1: begin vpn_mem[k] = VPNW'(k); valid_mem[k] = (k == 5) || (k == 700); end
                default: begin
                    vpn_mem[k]   = VPNW'($urandom_range(0, 40));
                    valid_mem[k] = 1'($urandom_range(0, 1));
                end
            endcase
        end
    endtask

    function automatic logic [15:0] model_l1(input logic [31:0] rs, input logic [31:0] re, input logic all);
        logic [15:0] m = '0;
        longint s_lo, s_hi, q_lo, q_hi;
        q_lo = longint'(rs);
        q_hi = longint'(re);
        for (int i = 0; i < N_SLICES; i++) begin
            s_lo = longint'(l1_start[i*AW +: AW]);
            s_hi = longint'(l1_end[i*AW +: AW]);
            if (l1_en[i] && (all || (q_hi >= q_lo && s_lo <= q_hi && s_hi >= q_lo))) m[i] = 1'b1;
        end
        return m;
    endfunction

    task automatic model_l2(input logic [31:0] rs, input logic [31:0] re, input logic all);
        longint lo, hi, q_lo, q_hi;
        q_lo = longint'(rs);
        q_hi = longint'(re);
        exp_q.delete();
        for (int k = 0; k < N_L2; k++) begin
            lo = longint'(vpn_mem[k]) * 4096;
            hi = lo + 4095;
            if (valid_mem[k] && (all || (q_hi >= q_lo && lo <= q_hi && hi >= q_lo))) exp_q.push_back(k);
        end
    endtask

    // Issue one request for a single cycle and wait (bounded) for done_o.
    task automatic applyStimulus(input logic [31:0] rs, input logic [31:0] re, input logic all);
        int n;
        @(negedge clk);
        snap_l1p  = l1_pulses;
        snap_l2   = l2_q.size();
        snap_done = done_cnt;
        snap_rd   = rd_cnt;
        checkOutput("ready before request", req_ready_o, 1);
        req_start = rs;
        req_end   = re;
        req_all   = all;
        req_valid = 1'b1;
        acc_cyc   = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        req_start = $urandom;
        req_end   = $urandom;
        req_all   = 1'($urandom_range(0, 1));
        n = 0;
        while (done_cnt == snap_done && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("done within bound", (done_cnt == snap_done) ? 0 : 1, 1);
        @(negedge clk);
    endtask

    task automatic run_row(input int r);
        int got_n;
        load_mem(vecs[r].mode);
        set_layout();
        l1_en = vecs[r].en;
        applyStimulus(vecs[r].rs, vecs[r].re, vecs[r].all);
        checkOutput($sformatf("row%0d l1 pulses", r), l1_pulses - snap_l1p, (vecs[r].exp_l1 != 0) ? 1 : 0);
        if (vecs[r].exp_l1 != 0) begin
            checkOutput($sformatf("row%0d l1 vector", r), l1_last, vecs[r].exp_l1);
            checkOutput($sformatf("row%0d l1 timing", r), l1_cyc - acc_cyc, 1);
        end
        got_n = l2_q.size() - snap_l2;
        checkOutput($sformatf("row%0d l2 clear count", r), got_n, vecs[r].exp_n);
        for (int j = 0; j < vecs[r].exp_n; j++) begin
            if (j < got_n)
                checkOutput($sformatf("row%0d l2 clear addr %0d", r, j), l2_q[snap_l2 + j],
                            (j == 0) ? vecs[r].exp_a : vecs[r].exp_b);
        end
        checkOutput($sformatf("row%0d done pulses", r), done_cnt - snap_done, 1);
        checkOutput($sformatf("row%0d latency", r), done_cyc - acc_cyc, LATENCY);
        checkOutput($sformatf("row%0d l2 reads", r), rd_cnt - snap_rd, N_L2);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, found, acc2, got_n, mism;
        logic [31:0] rs, re;
        logic all;
        logic [15:0] exp_l1;

        vecs[0] = '{32'h6000,     32'h7FFF,     1'b0, 16'hFFFF, 0, 16'h000C, 2, 6,   7};
        vecs[1] = '{32'h3000,     32'h4FFF,     1'b0, 16'hFFFF, 0, 16'h0001, 2, 3,   4};
        vecs[2] = '{32'h0,        32'h0,        1'b1, 16'hFFFF, 1, 16'hFFFF, 2, 5,   700};
        vecs[3] = '{32'h8000,     32'h7FFF,     1'b0, 16'hFFFF, 0, 16'h0000, 0, 0,   0};
        vecs[4] = '{32'h4000,     32'h13FFF,    1'b0, 16'h00F0, 1, 16'h00F0, 1, 5,   0};
        vecs[5] = '{32'h4FFF,     32'h5000,     1'b0, 16'hFFFF, 0, 16'h0003, 2, 4,   5};
        vecs[6] = '{32'h13FFF,    32'h13FFF,    1'b0, 16'hFFFF, 0, 16'h8000, 1, 19,  0};
        vecs[7] = '{32'h14000,    32'hFFFFFFFF, 1'b0, 16'hFFFF, 1, 16'h0000, 1, 700, 0};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_start = '0;
        req_end   = '0;
        req_all   = 1'b0;
        l1_en     = '0;
        set_layout();
        load_mem(0);

        repeat (2) @(negedge clk);
        checkOutput("reset ready", req_ready_o, 1);
        checkOutput("reset busy/lock/done", {busy_o, cfg_lock_o, done_o}, 0);
        checkOutput("reset l1_clr", l1_clr_o, 0);
        checkOutput("reset l2 strobes", {l2_rd_en_o, l2_clr_o, l2_rd_addr_o, l2_clr_addr_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 8; r++) run_row(r);

        // Backpressure: valid held high through the whole request.
        load_mem(0);
        set_layout();
        l1_en = 16'hFFFF;
        @(negedge clk);
        snap_done = done_cnt;
        req_start = 32'h6000;
        req_end   = 32'h7FFF;
        req_all   = 1'b0;
        req_valid = 1'b1;
        acc_cyc   = cyc;
        @(negedge clk);
        checkOutput("bp ready low while busy", req_ready_o, 0);
        checkOutput("bp lock high while busy", cfg_lock_o, 1);
        n = 0;
        while (done_cnt == snap_done && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("bp first done within bound", (done_cnt == snap_done) ? 0 : 1, 1);
        @(negedge clk);
        checkOutput("bp first latency", done_cyc - acc_cyc, LATENCY);
        checkOutput("bp ready after done", req_ready_o, 1);
        checkOutput("bp accept gap", cyc - done_cyc, 1);
        acc2 = cyc;
        @(negedge clk);
        checkOutput("bp second accepted", busy_o, 1);
        req_valid = 1'b0;
        n = 0;
        while (done_cnt < snap_done + 2 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("bp second done within bound", (done_cnt < snap_done + 2) ? 0 : 1, 1);
        @(negedge clk);
        checkOutput("bp second latency", done_cyc - acc2, LATENCY);

        // Reset in the middle of the L2 walk.
        @(negedge clk);
        snap_done = done_cnt;
        req_start = 32'h0;
        req_end   = 32'hFFFFFFFF;
        req_all   = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (l2_rd_en_o && l2_rd_addr_o == IDXW'(100)) found = 1;
        end
        checkOutput("walk reached index 100", found, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async reset ready", req_ready_o, 1);
        checkOutput("async reset outputs",
                    {l1_clr_o, l2_rd_en_o, l2_rd_addr_o, l2_clr_o, l2_clr_addr_o, cfg_lock_o, busy_o, done_o}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("no done after abort", done_cnt - snap_done, 0);
        run_row(0);

        // Randomized requests against the behavioural model.
        for (int t = 0; t < 8; t++) begin
            load_mem(2);
            set_rand_layout();
            l1_en = 16'($urandom);
            rs  = 32'($urandom_range(0, 32'h2A000));
            re  = ($urandom_range(0, 5) == 0) ? rs - 32'($urandom_range(1, 32'h2000))
                                              : rs + 32'($urandom_range(0, 32'h6000));
            all = ($urandom_range(0, 5) == 0);
            exp_l1 = model_l1(rs, re, all);
            model_l2(rs, re, all);
            applyStimulus(rs, re, all);
            checkOutput($sformatf("rnd%0d l1 pulses", t), l1_pulses - snap_l1p, (exp_l1 != 0) ? 1 : 0);
            if (exp_l1 != 0) checkOutput($sformatf("rnd%0d l1 vector", t), l1_last, exp_l1);
            got_n = l2_q.size() - snap_l2;
            checkOutput($sformatf("rnd%0d l2 clear count", t), got_n, exp_q.size());
            mism = 0;
            for (int j = 0; j < exp_q.size() && j < got_n; j++)
                if (l2_q[snap_l2 + j] != exp_q[j]) mism++;
            checkOutput($sformatf("rnd%0d l2 clear list mismatches", t), mism, 0);
            checkOutput($sformatf("rnd%0d latency", t), done_cyc - acc_cyc, LATENCY);
        end

        checkOutput("ready/busy/lock consistency", lock_bad, 0);
        checkOutput("l2 read index order", rd_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
